// File: rtl/miss_fill_unit.sv
// Miss/fill unit: queues block misses, issues in-order memory reads, fills the cache and wakes the wait buffer.
// Optional MISS_MERGE_EN: a miss to an already tracked block is accepted without allocating.
module miss_fill_unit #(
  parameter int ADDR_BITS      = 32,
  parameter int BLOCK_ID_START = 5,
  parameter int BLOCK_BITS     = 256,
  parameter int ENTRIES        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_valid,
  input  logic [ADDR_BITS-1:0]  miss_address,
  output logic                  miss_ready,
  output logic                  miss_pending,
  output logic                  mem_req_valid,
  output logic [ADDR_BITS-1:0]  mem_req_address,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [BLOCK_BITS-1:0] mem_resp_data,
  output logic                  mem_resp_ready,
  output logic                  fill_valid,
  output logic [ADDR_BITS-1:0]  fill_address,
  output logic [BLOCK_BITS-1:0] fill_data,
  input  logic                  fill_ready,
  output logic                  wb_invalidate,
  output logic [ADDR_BITS-1:0]  wb_address,
  input  logic                  wb_in_walk_mode
);

  localparam int PW = $clog2(ENTRIES);
  localparam int IW = ADDR_BITS - BLOCK_ID_START;
  localparam logic [PW:0] FULL = (PW+1)'(ENTRIES);
  localparam logic [BLOCK_ID_START-1:0] OFS0 = '0;

  typedef enum logic [1:0] {IDLE, FILL, WAKE} state_e;

  state_e                state_q;
  logic [ENTRIES-1:0]    vld_q;
  logic [IW-1:0]         id_q [ENTRIES];
  logic [PW-1:0]         tail_q, iss_q, head_q;
  logic [PW:0]           cnt_q, pend_q;
  logic [IW-1:0]         fid_q;
  logic [BLOCK_BITS-1:0] fdata_q;

  logic [IW-1:0] miss_id;
  logic [PW:0]   await_n;
  logic          hit, alloc, req_fire, resp_fire, free;
  logic          unused_ofs;

  assign miss_id    = miss_address[ADDR_BITS-1:BLOCK_ID_START];
  assign unused_ofs = ^miss_address[BLOCK_ID_START-1:0];

`ifdef MISS_MERGE_EN
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < ENTRIES; i++)
      if (vld_q[i] && id_q[i] == miss_id)
        hit = 1'b1;
  end
`else
  assign hit = 1'b0;
`endif

  assign miss_pending = hit;
  assign miss_ready   = (cnt_q != FULL) || hit;
  assign alloc        = miss_valid && miss_ready && !hit;

  // pend_q counts allocated-but-unissued slots, so a full queue is unambiguous
  assign mem_req_valid   = pend_q != '0;
  assign mem_req_address = mem_req_valid ? {id_q[iss_q], OFS0} : '0;
  assign req_fire        = mem_req_valid && mem_req_ready;

  assign mem_resp_ready = (state_q == IDLE) && (cnt_q != pend_q) && vld_q[head_q];
  assign resp_fire      = mem_resp_valid && mem_resp_ready;

  assign fill_valid   = state_q == FILL;
  assign fill_address = fill_valid ? {fid_q, OFS0} : '0;
  assign fill_data    = fill_valid ? fdata_q : '0;

  assign wb_invalidate = (state_q == WAKE) && !wb_in_walk_mode;
  assign wb_address    = (state_q == WAKE) ? {fid_q, OFS0} : '0;
  assign free          = wb_invalidate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vld_q   <= '0;
      tail_q  <= '0;
      iss_q   <= '0;
      head_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      if (free)
        vld_q[head_q] <= 1'b0;
      if (alloc)
        vld_q[tail_q] <= 1'b1;
      if (alloc)
        tail_q <= tail_q + PW'(1);
      if (free)
        head_q <= head_q + PW'(1);
      if (req_fire)
        iss_q <= iss_q + PW'(1);
      cnt_q  <= cnt_q + {{PW{1'b0}}, alloc} - {{PW{1'b0}}, free};
      pend_q <= pend_q + {{PW{1'b0}}, alloc} - {{PW{1'b0}}, req_fire};
      case (state_q)
        IDLE:    if (resp_fire) state_q <= FILL;
        FILL:    if (fill_ready) state_q <= WAKE;
        WAKE:    if (!wb_in_walk_mode) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (alloc)
      id_q[tail_q] <= miss_id;
    if (resp_fire) begin
      fid_q   <= id_q[head_q];
      fdata_q <= mem_resp_data;
    end
  end

  // responses arriving with no issued request still waiting are a protocol error
  assign await_n = cnt_q - pend_q - {{PW{1'b0}}, state_q != IDLE};

  resp_proto_a: assert property (@(posedge clk) disable iff (!rst_n)
    mem_resp_valid |-> await_n != '0);

endmodule

// File: tb/tb_miss_fill_unit.sv
// Randomised bench for miss_fill_unit against a queue-level reference model.
// Directed sequences cover reset, full queue, walk stall, free/alloc collision and merging.
module tb_miss_fill_unit;

  localparam int EN = 4;
  localparam logic [31:0] MASK = 32'hFFFF_FFE0;
`ifdef MISS_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         miss_valid = 1'b0;
  logic [31:0]  miss_address = '0;
  logic         miss_ready, miss_pending;
  logic         mem_req_valid;
  logic [31:0]  mem_req_address;
  logic         mem_req_ready = 1'b0;
  logic         mem_resp_valid = 1'b0;
  logic [255:0] mem_resp_data = '0;
  logic         mem_resp_ready;
  logic         fill_valid;
  logic [31:0]  fill_address;
  logic [255:0] fill_data;
  logic         fill_ready = 1'b0;
  logic         wb_invalidate;
  logic [31:0]  wb_address;
  logic         wb_in_walk_mode = 1'b0;

  always #5 clk = ~clk;

  miss_fill_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .miss_valid      (miss_valid),
    .miss_address    (miss_address),
    .miss_ready      (miss_ready),
    .miss_pending    (miss_pending),
    .mem_req_valid   (mem_req_valid),
    .mem_req_address (mem_req_address),
    .mem_req_ready   (mem_req_ready),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .mem_resp_ready  (mem_resp_ready),
    .fill_valid      (fill_valid),
    .fill_address    (fill_address),
    .fill_data       (fill_data),
    .fill_ready      (fill_ready),
    .wb_invalidate   (wb_invalidate),
    .wb_address      (wb_address),
    .wb_in_walk_mode (wb_in_walk_mode)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0]  mq[$];
  int           nis = 0;
  int           phase = 0;
  logic [31:0]  f_addr = '0;
  logic [255:0] f_data = '0;

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic bit m_hit();
    if (!MERGE) return 1'b0;
    foreach (mq[i])
      if (mq[i] == (miss_address & MASK)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [255:0] rd();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int awaiting();
    return nis - ((phase != 0) ? 1 : 0);
  endfunction

  task automatic model_clear();
    mq.delete();
    nis = 0;
    phase = 0;
  endtask

  task automatic check_outputs();
    bit h;
    h = m_hit();
    check("miss_ready", miss_ready, (mq.size() < EN) || h);
    check("miss_pending", miss_pending, h);
    check("req_valid", mem_req_valid, nis < mq.size());
    if (nis < mq.size()) check("req_addr", mem_req_address, mq[nis]);
    check("resp_ready", mem_resp_ready, phase == 0 && nis > 0);
    check("fill_valid", fill_valid, phase == 1);
    if (phase == 1) begin
      check("fill_addr", fill_address, f_addr);
      check("fill_data", fill_data, f_data);
    end
    check("wb_inv", wb_invalidate, phase == 2 && !wb_in_walk_mode);
    if (phase == 2) check("wb_addr", wb_address, f_addr);
    if (!rst_n)
      check("rst_addrs", {mem_req_address, fill_address, wb_address}, '0);
  endtask

  task automatic model_step();
    bit h, alloc, rq, rs, fr;
    int ph;
    h     = m_hit();
    alloc = miss_valid && ((mq.size() < EN) || h) && !h;
    rq    = (nis < mq.size()) && mem_req_ready;
    rs    = phase == 0 && nis > 0 && mem_resp_valid;
    fr    = phase == 2 && !wb_in_walk_mode;
    ph    = phase;
    if (rq) nis++;
    case (ph)
      0: if (rs) begin
           phase  = 1;
           f_addr = mq[0];
           f_data = mem_resp_data;
         end
      1: if (fill_ready) phase = 2;
      2: if (fr) begin
           phase = 0;
           void'(mq.pop_front());
           nis--;
         end
      default: phase = 0;
    endcase
    if (alloc) mq.push_back(miss_address & MASK);
  endtask

  task automatic cyc();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (rst_n) model_step();
    else model_clear();
    #1;
  endtask

  task automatic drive(input logic mv, input logic [31:0] ma, input logic rq,
                       input logic rv, input logic [255:0] d,
                       input logic fr, input logic wk);
    miss_valid      = mv;
    miss_address    = ma;
    mem_req_ready   = rq;
    mem_resp_valid  = rv;
    mem_resp_data   = d;
    fill_ready      = fr;
    wb_in_walk_mode = wk;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, '0, 0, 0, '0, 0, 0);
    model_clear();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, '0, 1, awaiting() > 0, rd(), 1, 0);
      cyc();
    end
  endtask

  logic [255:0] a5;
  int nreq;

  initial begin
    a5 = {32{8'hA5}};

    // reset values and a single miss end to end
    do_reset();
    check("rst_miss_ready", miss_ready, 1'b1);
    check("rst_resp_ready", mem_resp_ready, 1'b0);
    drive(1, 32'h1000_0044, 0, 0, '0, 0, 0);
    cyc();
    check("s1_req_v", mem_req_valid, 1'b1);
    check("s1_req_a", mem_req_address, 32'h1000_0040);
    drive(0, '0, 1, 0, '0, 0, 0);
    cyc();
    drive(0, '0, 0, 1, a5, 0, 0);
    cyc();
    check("s1_fill_v", fill_valid, 1'b1);
    check("s1_fill_a", fill_address, 32'h1000_0040);
    check("s1_fill_d", fill_data, a5);
    drive(0, '0, 0, 0, '0, 1, 0);
    cyc();
    check("s1_wb", wb_invalidate, 1'b1);
    check("s1_wb_a", wb_address, 32'h1000_0040);
    drive(0, '0, 0, 0, '0, 0, 0);
    cyc();
    check("s1_wb_off", wb_invalidate, 1'b0);
    check("s1_empty", mem_req_valid, 1'b0);

    // fill the queue with requests stalled
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 32'(i) << 8, 0, 0, '0, 0, 0);
      cyc();
    end
    drive(1, 32'h500, 0, 0, '0, 0, 0);
    #1 check("s2_full", miss_ready, 1'b0);
    cyc();
    check("s2_hold_a", mem_req_address, 32'h100);
    check("s2_hold_v", mem_req_valid, 1'b1);

    // walk mode holds off the wake, then the free cycle collides with a miss
    drive(0, '0, 1, 0, '0, 0, 0);
    cyc();
    drive(0, '0, 0, 1, rd(), 0, 0);
    cyc();
    drive(0, '0, 0, 0, '0, 1, 1);
    cyc();
    for (int k = 0; k < 5; k++) begin
      drive(0, '0, 0, 0, '0, 0, 1);
      #1 check("s3_wb_hold", wb_invalidate, 1'b0);
      check("s3_resp_rdy", mem_resp_ready, 1'b0);
      cyc();
    end
    drive(1, 32'h500, 0, 0, '0, 0, 0);
    #1 check("s4_wb", wb_invalidate, 1'b1);
    check("s4_noacc", miss_ready, 1'b0);
    cyc();
    drive(1, 32'h500, 0, 0, '0, 0, 0);
    #1 check("s4_acc", miss_ready, 1'b1);
    cyc();
    drain(40);

    // reset in the middle of a fill
    do_reset();
    drive(1, 32'h2000_0020, 0, 0, '0, 0, 0);
    cyc();
    drive(0, '0, 1, 0, '0, 0, 0);
    cyc();
    drive(0, '0, 0, 1, rd(), 0, 0);
    cyc();
    check("s5_fill_v", fill_valid, 1'b1);
    drive(0, '0, 0, 0, '0, 0, 0);
    rst_n = 1'b0;
    #1 check("s5_rst_fill", fill_valid, 1'b0);
    check("s5_rst_wb", wb_invalidate, 1'b0);
    check("s5_rst_rdy", miss_ready, 1'b1);
    check("s5_rst_req", mem_req_valid, 1'b0);
    model_clear();
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(0, '0, 0, 0, '0, 1, 0);
      cyc();
    end

    // same-block misses merge only when the feature is built in
    do_reset();
    drive(1, 32'h1000_0040, 0, 0, '0, 0, 0);
    cyc();
    drive(1, 32'h1000_005C, 0, 0, '0, 0, 0);
    #1 check("s6_pend", miss_pending, MERGE);
    check("s6_rdy", miss_ready, 1'b1);
    cyc();
    nreq = 0;
    for (int k = 0; k < 4; k++) begin
      drive(0, '0, 1, 0, '0, 0, 0);
      #1 if (mem_req_valid) nreq++;
      cyc();
    end
    check("s6_nreq", 32'(nreq), MERGE ? 32'd1 : 32'd2);
    drain(40);

    // randomised traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      drive(1'($urandom_range(0, 1)),
            32'h1000_0000 | (32'($urandom_range(0, 5)) << 5) | 32'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)),
            awaiting() > 0 && $urandom_range(0, 2) != 0,
            rd(),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0);
      cyc();
    end
    drain(60);
    check("end_empty", mem_req_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/miss_fill_unit.md
Name: miss_fill_unit

Overview:
- Refill side of the non-blocking data cache: accepts block misses, issues in-order block read requests to memory, and writes returned blocks into the cache.
- After each fill it drives the wait buffer's invalidate/walk trigger for the filled block, so parked loads and stores replay.
- Sits between the cache miss path, the memory/bus interface and the wait buffer.

Parameters:
- ADDR_BITS, 32, address width.
- BLOCK_ID_START, 5, first bit of the block ID; the offset is bits [BLOCK_ID_START-1:0].
- BLOCK_BITS, 256, cache block width.
- ENTRIES, 4, maximum outstanding misses (power of two, ≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- miss_valid  in  1  new miss request
- miss_address  in  ADDR_BITS  missing address (offset ignored)
- miss_ready  out  1  miss accepted this cycle when high with miss_valid
- miss_pending  out  1  comb: block of miss_address is already tracked
- mem_req_valid  out  1  block read request
- mem_req_address  out  ADDR_BITS  block base address, offset bits zero
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  block data returned, in request order
- mem_resp_data  in  BLOCK_BITS  returned block
- mem_resp_ready  out  1  unit can take a response
- fill_valid  out  1  cache write request
- fill_address  out  ADDR_BITS  block base being filled
- fill_data  out  BLOCK_BITS  block data
- fill_ready  in  1  cache accepted fill
- wb_invalidate  out  1  one-cycle pulse to the wait buffer search_invalidate
- wb_address  out  ADDR_BITS  block base for the wait buffer walk
- wb_in_walk_mode  in  1  wait buffer is walking; wb_invalidate is forbidden while high

Behaviour:
- Storage: ENTRIES circular slots (block address, valid). Three pointers: tail (allocate), issue (next to request), head (oldest issued). Occupancy count runs 0..ENTRIES.
- Allocate:
  - miss_ready = (count<ENTRIES).
  - On miss_valid&&miss_ready, write the block base at tail, set valid, advance tail. Wrap-around modulo ENTRIES.
- Issue:
  - mem_req_valid = (issue!=tail)||full-with-unissued.
  - mem_req_address = slot[issue].
  - issue advances on mem_req_valid&&mem_req_ready.
  - mem_req_valid and address are held stable until accepted.
- FSM:
  - IDLE→FILL on mem_resp_valid&&mem_resp_ready. mem_resp_ready=(state==IDLE)&&(head!=issue). The response and slot[head] address are captured into fill regs.
  - FILL: fill_valid=1 until fill_ready, then →WAKE.
  - WAKE: if !wb_in_walk_mode, pulse wb_invalidate=1 with wb_address=fill_address for exactly one cycle, free slot[head], advance head, decrement count, →IDLE. Otherwise stay in WAKE.
- Simultaneous allocate and free in one cycle: count unchanged, both pointers move.
- Freed slot is reusable from the next cycle. A miss that arrives in the same cycle as the free sees the full condition based on the pre-free count.
- mem_resp_valid when head==issue (nothing issued) is a protocol error: response ignored, assertion fires.
- Reset (any time, including mid-fill):
  - Pointers and count cleared, all valid=0, state=IDLE.
  - All outputs 0 except miss_ready=1 and mem_resp_ready=0.
  - Data regs are not reset.
- Latency:
  - Miss to mem_req_valid: 1 cycle when the queue is empty.
  - Response accept to fill_valid: 1 cycle.
  - fill_ready to wb_invalidate: 1 cycle minimum.

Optional Feature:
- MISS_MERGE_EN defined:
  - miss_pending = any valid slot's block ID equals miss_address's block ID.
  - A merging miss is accepted (miss_ready=1 even when full) and allocates nothing.
  - Matching continues until the slot is freed in WAKE.
- Not defined:
  - miss_pending tied 0.
  - Every accepted miss allocates and issues its own request; duplicate fills are legal.

Test Plan:
- Reset, then miss 0x1000_0044: next cycle mem_req_valid=1 with address 0x1000_0040. Accept it, return data 0xA5.., fill_ready=1 → fill_address=0x1000_0040, then wb_invalidate pulses once with wb_address=0x1000_0040, count=0.
- Four misses 0x100/0x200/0x300/0x400 with mem_req_ready=0 → miss_ready=0 after the 4th. A 5th miss 0x500 is stalled; request address held at 0x100.
- Hold wb_in_walk_mode=1 for 5 cycles during WAKE → wb_invalidate stays 0, then pulses the cycle after it drops; mem_resp_ready stays 0 throughout.
- Full queue; a new miss arrives in the free cycle → not accepted; accepted next cycle; tail wraps to slot 0.
- Assert rst_n=0 during FILL → fill_valid=0, wb_invalidate=0, miss_ready=1 immediately; the old response is not replayed after reset.
- With MISS_MERGE_EN, miss 0x1000_0040 then 0x1000_005C → one mem request only, miss_pending=1 on the second. Without the macro → two requests.
